store_buffer: RTL and testbench

- Write-back store buffer between the MEM-stage pipeline register and the 4 KB word-addressed data memory.
- Accepts word stores from the pipeline in one cycle and drains them to data memory one per cycle when the memory port is free.
- Loads in MEM get the youngest matching buffered data, or memory data on a miss.
- Hides data-memory port contention behind a small FIFO and keeps the `pc` tag alongside each store for the memory's write trace.

---
 rtl/sb_pkg.sv | 19 +
 rtl/sb_fwd_match.sv | 49 ++++
 rtl/store_buffer.sv | 132 +++++++++++++
 tb/tb_store_buffer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared definitions for the store buffer.
//   SB_DEPTH  default number of buffered stores (power of 2, >= 2)
//   SB_AW     default word-address bits used for forwarding (addr[AW+1:2])
//   SB_PTR_W  pointer width for the default depth
//   sb_entry_t one buffered store: valid flag, word address, data, pc tag
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 10;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic        valid;
        logic [29:0] addr;   // byte address bits [31:2]
        logic [31:0] data;
        logic [31:0] pc;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: finds the youngest valid buffered store whose word address
// matches the load word address.
//   entries  in   buffer storage array
//   headPtr  in   index of the oldest entry
//   ldWord   in   load word address (ld_addr[AW+1:2])
//   hit      out  at least one valid entry matches
//   hitIdx   out  index of the youngest matching entry (valid when hit)
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [PW-1:0]    headPtr,
    input  logic [AW-1:0]    ldWord,
    output logic             hit,
    output logic [PW-1:0]    hitIdx
);

    logic [PW-1:0] idx;
    logic          unusedFields;

    // Valid entries sit at head..tail-1 in age order. Walking from the head
    // and letting each later match override the earlier one leaves the
    // youngest match, i.e. the first one a search backward from tail-1 finds.
    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr + PW'(k);
            if (entries[idx].valid && entries[idx].addr[AW-1:0] == ldWord) begin
                hit    = 1'b1;
                hitIdx = idx;
            end
        end
    end

    // Upper address bits alias and data/pc are not part of the match.
    always_comb begin
        unusedFields = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            unusedFields = unusedFields ^ (^{entries[k].addr[29:AW], entries[k].data, entries[k].pc});
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: write-back FIFO between the MEM stage and the data memory.
// Stores are accepted in one cycle, drained one per cycle whenever the memory
// port is not needed by a load, and loads forward from the youngest buffered
// store to the same word.
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   st_valid/st_ready   store handshake; st_addr/st_data/st_pc store payload
//   ld_valid, ld_addr   load request; ld_data result; ld_stall holds MEM
//   dm_addr/dm_we/dm_wdata/dm_pc  data-memory port; dm_rdata read data
//   sb_empty            no stores pending
//
// Handshake: a store transfers on a rising edge where st_valid && st_ready.
// st_ready depends only on registered state (not full), never on st_valid.
// A store presented while st_ready is low is not taken; upstream must hold.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        ld_stall,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata,
    output logic        sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    sb_entry_t     entries [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [PW:0]   count;

    logic          isFull;
    logic          serveLoad;
    logic          doDrain;
    logic          doPush;
    logic          fwdHit;
    logic [PW-1:0] fwdIdx;
    logic          unusedStLow;

    assign isFull    = (count == FULL_COUNT);
    assign st_ready  = !isFull;
    assign sb_empty  = (count == '0);
    // Loads own the port unless the buffer is full; a full buffer must drain
    // first so the pipeline can make progress, and the load waits a cycle.
    assign serveLoad = ld_valid && !isFull;
    assign doDrain   = !serveLoad && (count != '0);
    assign doPush    = st_valid && !isFull;
    assign ld_stall  = ld_valid && isFull;
    assign unusedStLow = ^st_addr[1:0];

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd (
        .entries (entries),
        .headPtr (headPtr),
        .ldWord  (ld_addr[AW+1:2]),
        .hit     (fwdHit),
        .hitIdx  (fwdIdx)
    );

    assign ld_data = fwdHit ? entries[fwdIdx].data : dm_rdata;

    // Port outputs are forced to zero while reset is held so the memory sees
    // a quiet port even though ld_addr may still be toggling.
    always_comb begin
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_pc    = '0;
        if (reset) begin
            if (doDrain) begin
                dm_we    = 1'b1;
                dm_addr  = {entries[headPtr].addr, 2'b00};
                dm_wdata = entries[headPtr].data;
                dm_pc    = entries[headPtr].pc;
            end else begin
                dm_addr  = ld_addr;
            end
        end
    end

    // Push and pop never target the same slot: head == tail only when the
    // buffer is empty (no pop) or full (no push).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (doDrain) begin
                entries[headPtr].valid <= 1'b0;
                headPtr                <= headPtr + PW'(1);
            end
            if (doPush) begin
                entries[tailPtr] <= '{valid: 1'b1, addr: st_addr[31:2], data: st_data, pc: st_pc};
                tailPtr          <= tailPtr + PW'(1);
            end
            case ({doPush, doDrain})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A load issued alongside a store never sees that store; if both name the
    // same word the load would silently return stale data.
    sameCycleStoreLoad: assert property (@(posedge clk) disable iff (!reset)
        !(st_valid && ld_valid && st_addr[AW+1:2] == ld_addr[AW+1:2]));
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_wdata;
    logic [31:0] dm_pc;
    logic [31:0] dm_rdata;
    logic        sb_empty;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_pc    (st_pc),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_stall (ld_stall),
        .dm_addr  (dm_addr),
        .dm_we    (dm_we),
        .dm_wdata (dm_wdata),
        .dm_pc    (dm_pc),
        .dm_rdata (dm_rdata),
        .sb_empty (sb_empty)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [29:0] word;
        logic [31:0] data;
        logic [31:0] pc;
    } ref_t;

    ref_t        refQ[$];          // pending stores, oldest first
    logic [31:0] refMem [1024];    // memory image the model expects
    logic [31:0] dutMem [1024];    // memory image built from the DUT port

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkBit(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Youngest pending store to the same aliased word, else memory data.
    function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [31:0] memData);
        for (int i = refQ.size() - 1; i >= 0; i--) begin
            if (refQ[i].word[AW-1:0] == addr[AW+1:2]) return refQ[i].data;
        end
        return memData;
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic full;
        if (reset) begin
            full = (refQ.size() == DEPTH);
            chkBit("st_ready", st_ready, !full);
            chkBit("sb_empty", sb_empty, refQ.size() == 0);
            chkBit("ld_stall", ld_stall, ld_valid && full);
            if (ld_valid && !full) begin
                chkBit("dm_we_load", dm_we, 1'b0);
                chk("dm_addr_load", dm_addr, ld_addr);
                chk("ld_data", ld_data, refLoad(ld_addr, dm_rdata));
            end else if (refQ.size() > 0) begin
                chkBit("dm_we_drain", dm_we, 1'b1);
                chk("dm_addr_drain", dm_addr, {refQ[0].word, 2'b00});
                chk("dm_wdata", dm_wdata, refQ[0].data);
                chk("dm_pc", dm_pc, refQ[0].pc);
            end else begin
                chkBit("dm_we_idle", dm_we, 1'b0);
                chk("dm_addr_idle", dm_addr, ld_addr);
            end
        end
    end

    // ---------------- model update on the clock edge ----------------
    always @(posedge clk) begin
        logic full;
        logic pop;
        if (reset) begin
            full = (refQ.size() == DEPTH);
            pop  = !(ld_valid && !full) && (refQ.size() > 0);
            if (pop) begin
                refMem[refQ[0].word[9:0]] = refQ[0].data;
                void'(refQ.pop_front());
            end
            if (st_valid && !full) refQ.push_back('{st_addr[31:2], st_data, st_pc});
        end
    end

    always @(negedge reset) refQ.delete();

    always @(posedge clk) begin
        if (dm_we) dutMem[dm_addr[11:2]] <= dm_wdata;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [31:0] sp, input logic lv, input logic [31:0] la);
        @(posedge clk);
        #1;
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        st_pc    = sp;
        ld_valid = lv;
        ld_addr  = la;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Mixed operation table for the wrap-around section.
    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
    } op_t;

    op_t ops [10];

    // ---------------- directed sequence ----------------
    initial begin
        int memErrs;
        int budget;

        ops[0] = '{1'b1, 32'h0AC, 32'h000000AC, 1'b1, 32'h300};
        ops[1] = '{1'b1, 32'h0B0, 32'h000000B0, 1'b1, 32'h304};
        ops[2] = '{1'b0, 32'h000, 32'h00000000, 1'b1, 32'h0A4};
        ops[3] = '{1'b0, 32'h000, 32'h00000000, 1'b1, 32'h0A8};
        ops[4] = '{1'b1, 32'h0A8, 32'h000001A8, 1'b0, 32'h000};
        ops[5] = '{1'b0, 32'h000, 32'h00000000, 1'b1, 32'h0A8};
        ops[6] = '{1'b1, 32'h0B4, 32'h000000B4, 1'b1, 32'h308};
        ops[7] = '{1'b1, 32'h0B8, 32'h000000B8, 1'b0, 32'h000};
        ops[8] = '{1'b0, 32'h000, 32'h00000000, 1'b0, 32'h000};
        ops[9] = '{1'b1, 32'h0BC, 32'h000000BC, 1'b1, 32'h0B4};

        for (int i = 0; i < 1024; i++) begin
            refMem[i] = 32'h0;
            dutMem[i] = 32'h0;
        end

        // ---- reset ----
        reset    = 1'b0;
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        st_pc    = 32'h0;
        ld_valid = 1'b0;
        ld_addr  = 32'h44;
        dm_rdata = 32'h0BAD0000;
        #2;
        chkBit("rst_st_ready", st_ready, 1'b1);
        chkBit("rst_sb_empty", sb_empty, 1'b1);
        chkBit("rst_dm_we", dm_we, 1'b0);
        chkBit("rst_ld_stall", ld_stall, 1'b0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_dm_pc", dm_pc, 32'h0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;

        // ---- three stores drain in order ----
        cyc(1'b1, 32'h10, 32'hAAAA0001, 32'h100, 1'b0, 32'h0);
        chkBit("t1_we_c0", dm_we, 1'b0);
        cyc(1'b1, 32'h14, 32'hBBBB0002, 32'h104, 1'b0, 32'h0);
        chkBit("t1_we_c1", dm_we, 1'b1);
        chk("t1_addr_c1", dm_addr, 32'h10);
        chk("t1_data_c1", dm_wdata, 32'hAAAA0001);
        chk("t1_pc_c1", dm_pc, 32'h100);
        cyc(1'b1, 32'h10, 32'hCCCC0003, 32'h108, 1'b0, 32'h0);
        chkBit("t1_we_c2", dm_we, 1'b1);
        chk("t1_addr_c2", dm_addr, 32'h14);
        idle();
        chkBit("t1_we_c3", dm_we, 1'b1);
        chk("t1_data_c3", dm_wdata, 32'hCCCC0003);
        idle();
        chkBit("t1_we_c4", dm_we, 1'b0);
        chkBit("t1_empty", sb_empty, 1'b1);
        chk("t1_mem_w4", dutMem[4], 32'hCCCC0003);
        chk("t1_mem_w5", dutMem[5], 32'hBBBB0002);

        // ---- youngest match forwards ----
        cyc(1'b1, 32'h20, 32'h11, 32'h200, 1'b1, 32'h100);
        chk("t2_miss0", ld_data, 32'h0BAD0000);
        cyc(1'b1, 32'h20, 32'h22, 32'h204, 1'b1, 32'h104);
        chkBit("t2_we_blocked", dm_we, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h20);
        chk("t2_fwd_youngest", ld_data, 32'h22);
        chkBit("t2_no_stall", ld_stall, 1'b0);
        idle();
        chk("t2_drain_old", dm_wdata, 32'h11);
        idle();
        idle();
        chk("t2_mem_w8", dutMem[8], 32'h22);

        // ---- load miss ----
        cyc(1'b1, 32'h40, 32'h4040, 32'h300, 1'b1, 32'h200);
        dm_rdata = 32'hDEADBEEF;
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h44);
        chk("t3_miss_data", ld_data, 32'hDEADBEEF);
        chkBit("t3_miss_we", dm_we, 1'b0);
        chk("t3_miss_addr", dm_addr, 32'h44);
        idle();
        chk("t3_no_pop", dm_addr, 32'h40);
        idle();
        chkBit("t3_empty", sb_empty, 1'b1);

        // ---- full, drop, stall, alias ----
        cyc(1'b1, 32'h50,   32'h50505050, 32'h400, 1'b1, 32'h300);
        cyc(1'b1, 32'h54,   32'h54545454, 32'h404, 1'b1, 32'h300);
        cyc(1'b1, 32'h58,   32'h58585858, 32'h408, 1'b1, 32'h300);
        cyc(1'b1, 32'h1004, 32'h10040000, 32'h40C, 1'b1, 32'h300);
        cyc(1'b1, 32'h5C,   32'h5C5C5C5C, 32'h410, 1'b0, 32'h0);
        chkBit("t4_full_ready", st_ready, 1'b0);
        chk("t4_full_drain", dm_addr, 32'h50);
        cyc(1'b1, 32'h60,   32'h60606060, 32'h414, 1'b1, 32'h300);
        chkBit("t4_refill_ready", st_ready, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h4);
        chkBit("t4_stall", ld_stall, 1'b1);
        chk("t4_stall_drain", dm_addr, 32'h54);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h4);
        chkBit("t4_stall_gone", ld_stall, 1'b0);
        chk("t4_alias_fwd", ld_data, 32'h10040000);
        idle();
        idle();
        chk("t4_alias_addr", dm_addr, 32'h1004);
        idle();
        idle();
        chk("t4_mem_alias", dutMem[1], 32'h10040000);
        chk("t4_dropped", dutMem[23], 32'h0);

        // ---- push and pop together, then wrap-around ----
        cyc(1'b1, 32'hA0, 32'hA0, 32'h500, 1'b1, 32'h300);
        cyc(1'b1, 32'hA4, 32'hA4, 32'h504, 1'b1, 32'h300);
        cyc(1'b1, 32'hA8, 32'hA8, 32'h508, 1'b0, 32'h0);
        chk("t5_pushpop_addr", dm_addr, 32'hA0);
        chkBit("t5_pushpop_ready", st_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(ops[i].sv, ops[i].sa, ops[i].sd, 32'h600 + 32'(i), ops[i].lv, ops[i].la);
            if (i == 2) chkBit("t5_wrap_stall", ld_stall, 1'b1);
            if (i == 5) chk("t5_wrap_fwd", ld_data, 32'h1A8);
        end
        budget = 0;
        while (!sb_empty && budget < 20) begin
            idle();
            budget++;
        end
        chkBit("t5_drain_done", sb_empty, 1'b1);
        chk("t5_dropped", dutMem[46], 32'h0);

        // ---- reset in the middle of draining ----
        cyc(1'b1, 32'h80, 32'h80808080, 32'h700, 1'b1, 32'h300);
        cyc(1'b1, 32'h84, 32'h84848484, 32'h704, 1'b1, 32'h300);
        cyc(1'b1, 32'h88, 32'h88888888, 32'h708, 1'b1, 32'h300);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h44);
        chkBit("t6_pre_we", dm_we, 1'b1);
        #2 reset = 1'b0;
        #1;
        chkBit("t6_rst_we", dm_we, 1'b0);
        chkBit("t6_rst_empty", sb_empty, 1'b1);
        chkBit("t6_rst_ready", st_ready, 1'b1);
        chk("t6_rst_addr", dm_addr, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) begin
            idle();
            chkBit("t6_no_stale", dm_we, 1'b0);
        end
        chk("t6_mem_w32", dutMem[32], 32'h0);
        chk("t6_mem_w33", dutMem[33], 32'h0);
        chk("t6_mem_w34", dutMem[34], 32'h0);

        // ---- final memory image ----
        memErrs = 0;
        for (int i = 0; i < 1024; i++) begin
            if (dutMem[i] !== refMem[i]) memErrs++;
        end
        chk("mem_image", 32'(memErrs), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
